// File: rtl/bf16_skew_feeder.sv
// Operand-injection front end for the BF16 systolic array: buffers K vectors of N lanes
// and replays them with a diagonal skew (lane i delayed by i beats, padded with +0).
module bf16_skew_feeder #(
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [N-1:0]            out_lane_valid,
  output logic                    out_last,
  output logic                    done
);

  localparam int T  = K + N - 1;
  localparam int LW = (K > 1) ? $clog2(K) : 1;
  localparam int BW = (T > 1) ? $clog2(T) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(K - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(T - 1);

  typedef enum logic [1:0] {LOAD, PREP, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           load_cnt;
  logic [BW-1:0]           beat_cnt;
  logic [N*DATA_WIDTH-1:0] buf_mem [K];

  logic [BW-1:0]           sel_beat;
  logic [N*DATA_WIDTH-1:0] nxt_data;
  logic [N-1:0]            nxt_lane_valid;
  logic                    nxt_last;
  int                      row_diff;

  assign in_ready = (state_q == LOAD);

  // Tile buffer carries no reset; rows outside the valid diagonal are never shown.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      buf_mem[load_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_valid && load_cnt == LOAD_LAST) state_d = PREP;
      PREP:    state_d = STREAM;
      STREAM:  if (out_valid && out_ready && beat_cnt == BEAT_LAST) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Beat about to be registered: beat 0 when leaving PREP, otherwise the successor.
  always_comb begin
    sel_beat       = (state_q == PREP) ? '0 : beat_cnt + BW'(1);
    nxt_last       = (sel_beat == BEAT_LAST);
    nxt_data       = '0;
    nxt_lane_valid = '0;
    row_diff       = 0;
    for (int i = 0; i < N; i++) begin
      row_diff = int'(sel_beat) - i;
      if (row_diff >= 0 && row_diff < K) begin
        nxt_data[i*DATA_WIDTH +: DATA_WIDTH] = buf_mem[row_diff[LW-1:0]][i*DATA_WIDTH +: DATA_WIDTH];
        nxt_lane_valid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt       <= '0;
      beat_cnt       <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_lane_valid <= '0;
      out_last       <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            load_cnt <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + LW'(1);
          end
        end
        PREP: begin
          out_valid      <= 1'b1;
          out_data       <= nxt_data;
          out_lane_valid <= nxt_lane_valid;
          out_last       <= nxt_last;
          beat_cnt       <= '0;
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (beat_cnt == BEAT_LAST) begin
              out_valid      <= 1'b0;
              out_data       <= '0;
              out_lane_valid <= '0;
              out_last       <= 1'b0;
              done           <= 1'b1;
            end else begin
              beat_cnt       <= beat_cnt + BW'(1);
              out_data       <= nxt_data;
              out_lane_valid <= nxt_lane_valid;
              out_last       <= nxt_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
